// File: rtl/bp_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : bp_gshare
//  Purpose  : Branch predictor for the fetch stage. It predicts direction and
//             target combinationally, trains on resolutions returned from AGEX,
//             and raises a one-cycle flush/redirect when AGEX reports a
//             mispredict.
//  Config   : BP_GSHARE_EN defined   -> gshare (PC XOR global history index)
//             BP_GSHARE_EN undefined -> bimodal (PC-only index, history held 0)
//  Revision : 1.0 - initial release
// ============================================================================
module bp_gshare #(
  parameter int DBITS        = 32,
  parameter int BHR_BITS     = 8,
  parameter int BTB_IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,            // asynchronous, active-low
  input  logic [DBITS-1:0]    fe_pc_i,
  output logic                pred_taken_o,
  output logic [DBITS-1:0]    pred_target_o,
  output logic [BHR_BITS-1:0] pred_bhr_o,
  input  logic                upd_valid_i,
  input  logic [DBITS-1:0]    upd_pc_i,
  input  logic [BHR_BITS-1:0] upd_bhr_i,
  input  logic                upd_taken_i,
  input  logic [DBITS-1:0]    upd_target_i,
  input  logic                upd_mispredict_i,
  output logic                flush_o,
  output logic [DBITS-1:0]    redirect_pc_o
);

  localparam int PHT_ENTRIES = 1 << BHR_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS    = DBITS - BTB_IDX_BITS - 2;

  // Prediction state
  logic [1:0]          pht_q       [PHT_ENTRIES];
  logic                btb_valid_q [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [DBITS-1:0]    btb_tgt_q   [BTB_ENTRIES];
  logic [BHR_BITS-1:0] bhr_q, bhr_d;

  // Flush / redirect state
  logic                flush_q, flush_d;
  logic [DBITS-1:0]    redirect_q, redirect_d;

  // Index and lookup wires
  logic [BHR_BITS-1:0]     fe_pht_idx, upd_pht_idx;
  logic [BTB_IDX_BITS-1:0] fe_btb_idx, upd_btb_idx;
  logic [TAG_BITS-1:0]     fe_tag, upd_tag;
  logic                    fe_hit;
  logic [1:0]              pht_cur, pht_cnt_d;

`ifdef BP_GSHARE_EN
  assign fe_pht_idx  = fe_pc_i[BHR_BITS+1:2] ^ bhr_q;
  assign upd_pht_idx = upd_pc_i[BHR_BITS+1:2] ^ upd_bhr_i;
`else
  // Bimodal: history takes no part in indexing, the snapshot is ignored.
  logic unused_upd_bhr;
  assign fe_pht_idx     = fe_pc_i[BHR_BITS+1:2];
  assign upd_pht_idx    = upd_pc_i[BHR_BITS+1:2];
  assign unused_upd_bhr = ^upd_bhr_i;
`endif

  assign fe_btb_idx  = fe_pc_i[BTB_IDX_BITS+1:2];
  assign upd_btb_idx = upd_pc_i[BTB_IDX_BITS+1:2];
  assign fe_tag      = fe_pc_i[DBITS-1:BTB_IDX_BITS+2];
  assign upd_tag     = upd_pc_i[DBITS-1:BTB_IDX_BITS+2];

  // Lookup reads only registered state, so a same-cycle update is not visible.
  assign fe_hit        = btb_valid_q[fe_btb_idx] && (btb_tag_q[fe_btb_idx] == fe_tag);
  assign pred_taken_o  = fe_hit && pht_q[fe_pht_idx][1];
  assign pred_target_o = pred_taken_o ? btb_tgt_q[fe_btb_idx] : fe_pc_i + DBITS'(4);
  assign pred_bhr_o    = bhr_q;
  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;

  assign pht_cur = pht_q[upd_pht_idx];

  // Saturating 2-bit counter step for the entry being trained
  always_comb begin
    pht_cnt_d = pht_cur;
    if (upd_taken_i) begin
      if (pht_cur != 2'b11) pht_cnt_d = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_cnt_d = pht_cur - 2'b01;
    end
  end

  // History is rebuilt from the carried snapshot so it self-repairs after a flush
  always_comb begin
    bhr_d = bhr_q;
`ifdef BP_GSHARE_EN
    if (upd_valid_i) bhr_d = {upd_bhr_i[BHR_BITS-2:0], upd_taken_i};
`else
    bhr_d = '0;
`endif
  end

  // Mispredict produces a single-cycle flush; redirect holds between flushes
  always_comb begin
    flush_d    = upd_valid_i && upd_mispredict_i;
    redirect_d = redirect_q;
    if (flush_d) redirect_d = upd_taken_i ? upd_target_i : upd_pc_i + DBITS'(4);
  end

  // PHT counters, reset to weakly not-taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (upd_valid_i) begin
      pht_q[upd_pht_idx] <= pht_cnt_d;
    end
  end

  // BTB valid bits; only taken resolutions allocate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (upd_valid_i && upd_taken_i) begin
      btb_valid_q[upd_btb_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload, qualified by the valid bit so it needs no reset
  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      btb_tag_q[upd_btb_idx] <= upd_tag;
      btb_tgt_q[upd_btb_idx] <= upd_target_i;
    end
  end

  // History, flush and redirect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bhr_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      bhr_q      <= bhr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

endmodule
`default_nettype wire
